// File: rtl/fetch_pkg.sv
// Shared widths, PC source encodings and memory FSM states for the fetch unit.
package fetch_pkg;

  localparam int DATA_W   = 16;
  localparam int OPCODE_W = 4;

  // Next-PC source selected by PCData
  typedef enum logic [1:0] {
    SEL_INC    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JR     = 2'd3
  } PcSel;

  // Memory port handshake states
  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } MemState;

  // Pseudo-direct jump target: keep the PC's top nibble, take the rest from IR
  function automatic logic [DATA_W-1:0] jumpTarget(input logic [DATA_W-1:0] pc,
                                                    input logic [DATA_W-1:0] ir);
    return {pc[DATA_W-1:DATA_W-OPCODE_W], ir[DATA_W-OPCODE_W-1:0]};
  endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// Memory port handshake: a request completes in the same cycle when ack is
// already high, otherwise its address/data/direction are frozen until ack.
module mem_port_fsm
  import fetch_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              iRegWrite,
  input  logic [DATA_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              Stall,
  output logic              accessDone,
  output logic              accessWrite,
  output logic              accessIRegWrite
);

  MemState           state;
  logic              latWe;
  logic              latIrw;
  logic [DATA_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic              liveReq;

  assign liveReq = memRead | memWrite;

  // Present either the live request (idle) or the frozen one (waiting); reset silences the port
  always_comb begin
    mem_req         = 1'b0;
    mem_we          = memWrite;
    mem_addr        = reqAddr;
    mem_wdata       = reqWdata;
    accessIRegWrite = iRegWrite;
    if (RST_N) begin
      if (state == MEM_WAIT) begin
        mem_req         = 1'b1;
        mem_we          = latWe;
        mem_addr        = latAddr;
        mem_wdata       = latWdata;
        accessIRegWrite = latIrw;
      end else begin
        mem_req = liveReq;
      end
    end
    Stall       = mem_req & ~mem_ack;
    accessDone  = mem_req & mem_ack;
    accessWrite = mem_we;
  end

  // State register and request latch; a write wins when read and write are both asked for
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= MEM_IDLE;
      latWe    <= 1'b0;
      latIrw   <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (liveReq && !mem_ack) begin
            state    <= MEM_WAIT;
            latWe    <= memWrite;
            latIrw   <= iRegWrite;
            latAddr  <= reqAddr;
            latWdata <= reqWdata;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state <= MEM_IDLE;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC, IR and MDR registers around a stalling memory port.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                PCWrite,
  input  logic                PCWriteBeq,
  input  logic                PCWriteBne,
  input  logic [1:0]          PCData,
  input  logic                IRegWrite,
  input  logic                IorD,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                Zero,
  input  logic [DATA_W-1:0]   ALUResult,
  input  logic [DATA_W-1:0]   ALUOut,
  input  logic [DATA_W-1:0]   RegA,
  input  logic [DATA_W-1:0]   RegB,
  output logic [OPCODE_W-1:0] Opcode,
  output logic [DATA_W-1:0]   IR,
  output logic [DATA_W-1:0]   PC,
  output logic [DATA_W-1:0]   MDR,
  output logic                Stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  logic              pcLoad;
  logic [DATA_W-1:0] nextPc;
  logic [DATA_W-1:0] reqAddr;
  logic              accessDone;
  logic              accessWrite;
  logic              accessIRegWrite;

  assign reqAddr = IorD ? ALUOut : PC;
  assign Opcode  = IR[DATA_W-1 -: OPCODE_W];
  assign pcLoad  = (PCWrite | (PCWriteBeq & Zero) | (PCWriteBne & ~Zero)) & ~Stall;

  mem_port_fsm memPort (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .memRead         (MemRead),
    .memWrite        (MemWrite),
    .iRegWrite       (IRegWrite),
    .reqAddr         (reqAddr),
    .reqWdata        (RegB),
    .mem_ack         (mem_ack),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .Stall           (Stall),
    .accessDone      (accessDone),
    .accessWrite     (accessWrite),
    .accessIRegWrite (accessIRegWrite)
  );

  // Choose the next PC from the incrementer, branch target, jump field or register
  always_comb begin
    nextPc = ALUResult;
    case (PcSel'(PCData))
      SEL_INC:    nextPc = ALUResult;
      SEL_BRANCH: nextPc = ALUOut;
      SEL_JUMP:   nextPc = jumpTarget(PC, IR);
      SEL_JR:     nextPc = RegA;
      default:    nextPc = ALUResult;
    endcase
  end

  // PC register, frozen while the memory port is stalling
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PC <= '0;
    end else if (pcLoad) begin
      PC <= nextPc;
    end
  end

  // Completed reads land in MDR, and in IR too when this access was an instruction fetch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IR  <= '0;
      MDR <= '0;
    end else if (accessDone && !accessWrite) begin
      MDR <= mem_rdata;
      if (accessIRegWrite) begin
        IR <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver plays the memory, runs a
// behavioural model and queues expectations; a monitor compares on negedges.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        PCWrite = 1'b0, PCWriteBeq = 1'b0, PCWriteBne = 1'b0;
  logic [1:0]  PCData = 2'd0;
  logic        IRegWrite = 1'b0, IorD = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, Zero = 1'b0;
  logic [15:0] ALUResult = '0, ALUOut = '0, RegA = '0, RegB = '0;
  logic [3:0]  Opcode;
  logic [15:0] IR, PC, MDR;
  logic        Stall;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pcWrite, beq, bne;
    logic [1:0] pcData;
    logic       iRegWrite, iorD, memRead, memWrite, zero, ack;
    logic [15:0] aluResult, aluOut, regA, regB, rdata;
  } Stim;

  typedef struct {
    logic [15:0] pc, ir, mdr, addr, wdata;
    logic        req, we, stall;
  } Snap;

  typedef struct {
    logic [15:0] addr, wdata;
    logic        we;
  } Txn;

  Snap snapQ[$];
  Txn  txnQ[$];

  // Reference model state
  logic [15:0] mPc = '0, mIr = '0, mMdr = '0;
  logic        mPend = 1'b0, mPendWe = 1'b0, mPendIrw = 1'b0;
  logic [15:0] mPendAddr = '0, mPendWdata = '0;

  fetch_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .PCWrite(PCWrite), .PCWriteBeq(PCWriteBeq), .PCWriteBne(PCWriteBne),
    .PCData(PCData), .IRegWrite(IRegWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .Zero(Zero),
    .ALUResult(ALUResult), .ALUOut(ALUOut), .RegA(RegA), .RegB(RegB),
    .Opcode(Opcode), .IR(IR), .PC(PC), .MDR(MDR), .Stall(Stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic Stim idleStim();
    Stim s;
    s = '{pcWrite: 1'b0, beq: 1'b0, bne: 1'b0, pcData: 2'd0, iRegWrite: 1'b0, iorD: 1'b0,
          memRead: 1'b0, memWrite: 1'b0, zero: 1'b0, ack: 1'b0,
          aluResult: 16'h0, aluOut: 16'h0, regA: 16'h0, regB: 16'h0, rdata: 16'h0};
    return s;
  endfunction

  // Drive one cycle, queue what the model says the DUT shows this cycle, advance the model
  task automatic applyStimulus(input Stim s);
    Snap e;
    Txn t;
    logic req, we, irw, stall, take;
    logic [15:0] addr, wdata, newPc;
    PCWrite = s.pcWrite; PCWriteBeq = s.beq; PCWriteBne = s.bne; PCData = s.pcData;
    IRegWrite = s.iRegWrite; IorD = s.iorD; MemRead = s.memRead; MemWrite = s.memWrite;
    Zero = s.zero; ALUResult = s.aluResult; ALUOut = s.aluOut; RegA = s.regA; RegB = s.regB;
    mem_rdata = s.rdata; mem_ack = s.ack;
    if (!RST_N) begin
      mPc = '0; mIr = '0; mMdr = '0;
      mPend = 1'b0; mPendWe = 1'b0; mPendIrw = 1'b0; mPendAddr = '0; mPendWdata = '0;
      e = '{pc: 16'h0, ir: 16'h0, mdr: 16'h0, addr: 16'h0, wdata: 16'h0, req: 1'b0, we: 1'b0, stall: 1'b0};
      snapQ.push_back(e);
    end else begin
      if (mPend) begin
        req = 1'b1; we = mPendWe; addr = mPendAddr; wdata = mPendWdata; irw = mPendIrw;
      end else begin
        req = s.memRead | s.memWrite; we = s.memWrite;
        addr = s.iorD ? s.aluOut : mPc; wdata = s.regB; irw = s.iRegWrite;
      end
      stall = req && !s.ack;
      e = '{pc: mPc, ir: mIr, mdr: mMdr, addr: addr, wdata: wdata, req: req, we: we, stall: stall};
      snapQ.push_back(e);
      if (req && s.ack) begin
        t = '{addr: addr, wdata: wdata, we: we};
        txnQ.push_back(t);
      end
      take = s.pcWrite || (s.beq && s.zero) || (s.bne && !s.zero);
      newPc = mPc;
      if (take && !stall) begin
        case (s.pcData)
          2'd0: newPc = s.aluResult;
          2'd1: newPc = s.aluOut;
          2'd2: newPc = {mPc[15:12], mIr[11:0]};
          default: newPc = s.regA;
        endcase
      end
      if (req && s.ack && !we) begin
        mMdr = s.rdata;
        if (irw) mIr = s.rdata;
      end
      if (!mPend && stall) begin
        mPendAddr = addr; mPendWe = we; mPendWdata = wdata; mPendIrw = irw;
      end
      mPend = stall;
      mPc = newPc;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic setPc(input logic [15:0] value);
    Stim s;
    s = idleStim(); s.pcWrite = 1'b1; s.pcData = 2'd3; s.regA = value;
    applyStimulus(s);
  endtask

  task automatic fetchNow(input logic [15:0] word);
    Stim s;
    s = idleStim(); s.memRead = 1'b1; s.iRegWrite = 1'b1; s.ack = 1'b1; s.rdata = word;
    applyStimulus(s);
  endtask

  // Monitor: compare each queued snapshot, and each completed handshake against the transaction queue
  Snap me;
  Txn  mt;
  always @(negedge CLK) begin
    if (snapQ.size() > 0) begin
      me = snapQ.pop_front();
      checkOutput("pc", PC, me.pc);
      checkOutput("ir", IR, me.ir);
      checkOutput("mdr", MDR, me.mdr);
      checkOutput("opcode", {12'h0, Opcode}, {12'h0, me.ir[15:12]});
      checkOutput("mem_req", {15'h0, mem_req}, {15'h0, me.req});
      checkOutput("stall", {15'h0, Stall}, {15'h0, me.stall});
      if (me.req) begin
        checkOutput("mem_we", {15'h0, mem_we}, {15'h0, me.we});
        checkOutput("mem_addr", mem_addr, me.addr);
        checkOutput("mem_wdata", mem_wdata, me.wdata);
      end
    end
    if (RST_N && mem_req && mem_ack) begin
      if (txnQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL txn_unexpected: got addr %h we %b expected no access", mem_addr, mem_we);
      end else begin
        mt = txnQ.pop_front();
        checkOutput("txn_addr", mem_addr, mt.addr);
        checkOutput("txn_we", {15'h0, mem_we}, {15'h0, mt.we});
        checkOutput("txn_wdata", mem_wdata, mt.wdata);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Stim s;
    @(posedge CLK); #1;
    applyStimulus(idleStim());
    s = idleStim(); s.memRead = 1'b1; s.ack = 1'b0;
    applyStimulus(s);
    RST_N = 1'b1;

    // Zero-wait fetch
    fetchNow(16'h8123);
    checkOutput("zw_ir", IR, 16'h8123);
    checkOutput("zw_opcode", {12'h0, Opcode}, 16'h0008);

    // Waited fetch; address inputs change while waiting and must be ignored
    for (int i = 0; i < 3; i++) begin
      s = idleStim(); s.memRead = 1'b1; s.iRegWrite = 1'b1; s.ack = 1'b0;
      s.iorD = (i != 0); s.aluOut = 16'h7770 + 16'(i); s.rdata = 16'hDEAD;
      applyStimulus(s);
    end
    s = idleStim(); s.memRead = 1'b1; s.iRegWrite = 1'b1; s.ack = 1'b1; s.rdata = 16'hE00F;
    s.iorD = 1'b1; s.aluOut = 16'h1111;
    applyStimulus(s);
    checkOutput("wait_opcode", {12'h0, Opcode}, 16'h000E);

    // Conditional branches
    setPc(16'h0010);
    s = idleStim(); s.pcData = 2'd1; s.aluOut = 16'h0040; s.beq = 1'b1; s.zero = 1'b1;
    applyStimulus(s);
    checkOutput("beq_taken", PC, 16'h0040);
    setPc(16'h0010);
    s.zero = 1'b0;
    applyStimulus(s);
    checkOutput("beq_not_taken", PC, 16'h0010);
    s = idleStim(); s.pcData = 2'd1; s.aluOut = 16'h0040; s.bne = 1'b1; s.zero = 1'b0;
    applyStimulus(s);
    checkOutput("bne_taken", PC, 16'h0040);
    s = idleStim(); s.pcData = 2'd1; s.aluOut = 16'h0080; s.beq = 1'b1; s.bne = 1'b1; s.zero = 1'b1;
    applyStimulus(s);
    checkOutput("beq_bne_both", PC, 16'h0080);

    // Jump, jump register, PC+2 wrap
    fetchNow(16'h2ABC);
    setPc(16'h5000);
    s = idleStim(); s.pcWrite = 1'b1; s.pcData = 2'd2;
    applyStimulus(s);
    checkOutput("jump", PC, 16'h5ABC);
    setPc(16'hFFFE);
    checkOutput("jr", PC, 16'hFFFE);
    s = idleStim(); s.pcWrite = 1'b1; s.pcData = 2'd0; s.aluResult = 16'hFFFE + 16'h0002;
    applyStimulus(s);
    checkOutput("pc_wrap", PC, 16'h0000);

    // PC load blocked by a stall, then allowed in the ack cycle
    s = idleStim(); s.memRead = 1'b1; s.ack = 1'b0; s.pcWrite = 1'b1; s.pcData = 2'd3; s.regA = 16'h1234;
    applyStimulus(s);
    checkOutput("stall_gates_pc", PC, 16'h0000);
    s.ack = 1'b1; s.regA = 16'h2222; s.rdata = 16'h4444;
    applyStimulus(s);
    checkOutput("ack_cycle_pc", PC, 16'h2222);
    // Zero-wait access with a simultaneous PC load uses the old PC as address
    s = idleStim(); s.memRead = 1'b1; s.iRegWrite = 1'b1; s.ack = 1'b1; s.rdata = 16'h3456;
    s.pcWrite = 1'b1; s.pcData = 2'd3; s.regA = 16'h3000;
    applyStimulus(s);

    // Write with one wait cycle
    s = idleStim(); s.memWrite = 1'b1; s.iorD = 1'b1; s.aluOut = 16'h0100; s.regB = 16'h1234;
    s.iRegWrite = 1'b1; s.ack = 1'b0; s.rdata = 16'hBAD0;
    applyStimulus(s);
    s.ack = 1'b1; s.regB = 16'h9999;
    applyStimulus(s);
    checkOutput("write_ir_kept", IR, 16'h3456);

    // Reset in the middle of a waited access, then a stray ack
    s = idleStim(); s.memRead = 1'b1; s.iRegWrite = 1'b1; s.ack = 1'b0;
    applyStimulus(s);
    RST_N = 1'b0;
    #1;
    checkOutput("rst_pc", PC, 16'h0000);
    checkOutput("rst_mem_req", {15'h0, mem_req}, 16'h0000);
    applyStimulus(s);
    RST_N = 1'b1;
    s = idleStim(); s.ack = 1'b1; s.rdata = 16'hFFFF;
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("stray_ack_ir", IR, 16'h0000);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      logic keepIrw;
      keepIrw = IRegWrite;
      s.pcWrite   = ($urandom_range(0, 3) == 0);
      s.beq       = ($urandom_range(0, 3) == 0);
      s.bne       = ($urandom_range(0, 3) == 0);
      s.pcData    = 2'($urandom_range(0, 3));
      s.iRegWrite = mPend ? keepIrw : 1'($urandom_range(0, 1));
      s.iorD      = 1'($urandom_range(0, 1));
      s.memRead   = 1'($urandom_range(0, 1));
      s.memWrite  = ($urandom_range(0, 3) == 0);
      s.zero      = 1'($urandom_range(0, 1));
      s.ack       = 1'($urandom_range(0, 1));
      s.aluResult = 16'($urandom);
      s.aluOut    = 16'($urandom);
      s.regA      = 16'($urandom);
      s.regB      = 16'($urandom);
      s.rdata     = 16'($urandom);
      RST_N = ($urandom_range(0, 127) != 0);
      applyStimulus(s);
    end
    RST_N = 1'b1;
    applyStimulus(idleStim());

    @(negedge CLK); #1;
    checkOutput("snap_queue_drained", 16'(snapQ.size()), 16'h0000);
    checkOutput("txn_queue_drained", 16'(txnQ.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
